// File: rtl/rv64g_l2_pkg.sv
// Shared encodings for the L2 directory coherence controller: permissions,
// grant caps, controller states and the onehot helper.
package rv64g_l2_pkg;

  localparam logic [1:0] PERM_NTOB = 2'd0;
  localparam logic [1:0] PERM_NTOT = 2'd1;
  localparam logic [1:0] PERM_BTOT = 2'd2;

  localparam logic CAP_BRANCH = 1'b0;
  localparam logic CAP_TRUNK  = 1'b1;

  localparam int unsigned MAX_CORES = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PSEND,
    S_PWAIT,
    S_WRITE,
    S_GRANT
  } state_e;

  // Callers truncate the result to their own core count.
  function automatic logic [MAX_CORES-1:0] onehot(input logic [31:0] id);
    return {{(MAX_CORES-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/rv64g_l2_probe_tracker.sv
// Outstanding-probe bookkeeping: pending mask, ack filtering and the sticky
// flag recording whether any real ack returned dirty data.
module rv64g_l2_probe_tracker
  import rv64g_l2_pkg::*;
#(
  parameter  int CORES = 4,
  localparam int CW    = $clog2(CORES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CORES-1:0] load_mask_i,
  input  logic             active_i,
  input  logic             ack_valid_i,
  input  logic [CW-1:0]    ack_src_i,
  input  logic             ack_dirty_i,
  output logic             dirty_seen_o,
  output logic             done_o
);

  logic [CORES-1:0] pending, pending_nxt, ack_oh;
  logic             ack_hit;

  assign ack_oh      = CORES'(onehot(32'(ack_src_i)));
  // Acks from cores that are not pending are dropped entirely, dirty bit included.
  assign ack_hit     = active_i & ack_valid_i & (|(pending & ack_oh));
  assign pending_nxt = ack_hit ? (pending & ~ack_oh) : pending;
  assign done_o      = ~|pending_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      dirty_seen_o <= 1'b0;
    end else if (load_i) begin
      pending      <= load_mask_i;
      dirty_seen_o <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (ack_hit && ack_dirty_i) dirty_seen_o <= 1'b1;
    end
  end

endmodule

// File: rtl/rv64g_l2_dir_ctrl.sv
// Single-transaction coherence controller: reads a directory entry, probes
// other cores as needed, writes the updated entry back and issues the Grant.
module rv64g_l2_dir_ctrl
  import rv64g_l2_pkg::*;
#(
  parameter  int SETS  = 256,
  parameter  int WAYS  = 16,
  parameter  int CORES = 4,
  localparam int SW    = $clog2(SETS),
  localparam int WW    = $clog2(WAYS),
  localparam int CW    = $clog2(CORES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SW-1:0]         req_set_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [CW-1:0]         req_src_i,
  input  logic [1:0]            req_perm_i,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*CW-1:0]    dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [CW-1:0]         dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic                  probe_valid_o,
  input  logic                  probe_ready_i,
  output logic [CORES-1:0]      probe_mask_o,
  output logic                  probe_to_n_o,
  input  logic                  ack_valid_i,
  input  logic [CW-1:0]         ack_src_i,
  input  logic                  ack_dirty_i,
  output logic                  wb_dirty_o,
  output logic                  grant_valid_o,
  input  logic                  grant_ready_i,
  output logic [CW-1:0]         grant_src_o,
  output logic                  grant_perm_o,
  output logic                  busy_o
);

  typedef struct packed {
    logic [SW-1:0] set;
    logic [WW-1:0] way;
    logic [CW-1:0] src;
    logic [1:0]    perm;
  } req_t;

  typedef struct packed {
    logic             v;
    logic [CORES-1:0] s;
    logic             ov;
    logic [CW-1:0]    oid;
    logic             d;
  } ent_t;

  state_e           state;
  req_t             req_q;
  ent_t             ent_q, rd_ent;
  logic [CORES-1:0] mask_q, mask_c, oh_src, oh_oid_rd, oh_oid_q;
  logic             to_n_q, is_ntob, dirty_seen, trk_done, wb_c;

  assign dir_rd_set_o = req_q.set;
  assign is_ntob      = (req_q.perm == PERM_NTOB);

  always_comb begin
    rd_ent.v   = dir_rd_valid_i[req_q.way];
    rd_ent.s   = dir_rd_sharers_i[req_q.way*CORES +: CORES];
    rd_ent.ov  = dir_rd_owner_valid_i[req_q.way];
    rd_ent.oid = dir_rd_owner_id_i[req_q.way*CW +: CW];
    rd_ent.d   = dir_rd_dirty_i[req_q.way];
  end

  assign oh_src    = CORES'(onehot(32'(req_q.src)));
  assign oh_oid_rd = CORES'(onehot(32'(rd_ent.oid)));
  assign oh_oid_q  = CORES'(onehot(32'(ent_q.oid)));

  // Branch requests only disturb a foreign owner; trunk requests strip every other holder.
  always_comb begin
    mask_c = '0;
    if (is_ntob) begin
      if (rd_ent.v && rd_ent.ov && (rd_ent.oid != req_q.src)) mask_c = oh_oid_rd;
    end else if (rd_ent.v) begin
      mask_c = (rd_ent.s | (rd_ent.ov ? oh_oid_rd : '0)) & ~oh_src;
    end
  end

  rv64g_l2_probe_tracker #(.CORES(CORES)) u_trk (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (state == S_READ),
    .load_mask_i (mask_c),
    .active_i    ((state == S_PSEND) || (state == S_PWAIT)),
    .ack_valid_i (ack_valid_i),
    .ack_src_i   (ack_src_i),
    .ack_dirty_i (ack_dirty_i),
    .dirty_seen_o(dirty_seen),
    .done_o      (trk_done)
  );

  // Entry to write back; a demoted owner becomes a sharer and its dirt moves to L2.
  always_comb begin
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    wb_c                 = dirty_seen;
    if (is_ntob) begin
      dir_wr_sharers_o = (ent_q.v ? ent_q.s : '0) | oh_src | ((mask_q != '0) ? oh_oid_q : '0);
      wb_c             = dirty_seen | (ent_q.v & ent_q.d);
    end else begin
      dir_wr_owner_valid_o = 1'b1;
      dir_wr_owner_id_o    = req_q.src;
      dir_wr_dirty_o       = ent_q.v & ent_q.ov & (ent_q.oid == req_q.src) & ent_q.d;
      wb_c                 = dirty_seen | (ent_q.v & ent_q.ov & ent_q.d & (ent_q.oid != req_q.src));
    end
  end

  assign dir_wr_set_o   = req_q.set;
  assign dir_wr_way_o   = req_q.way;
  assign dir_wr_valid_o = 1'b1;
  assign wb_dirty_o     = dir_we_o & wb_c;
  assign probe_mask_o   = mask_q;
  assign probe_to_n_o   = to_n_q;
  assign grant_src_o    = req_q.src;
  assign grant_perm_o   = is_ntob ? CAP_BRANCH : CAP_TRUNK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_q         <= '0;
      ent_q         <= '0;
      mask_q        <= '0;
      to_n_q        <= 1'b0;
      req_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      probe_valid_o <= 1'b0;
      dir_we_o      <= 1'b0;
      grant_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid_i) begin
          req_q       <= '{set: req_set_i, way: req_way_i, src: req_src_i, perm: req_perm_i};
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          state       <= S_READ;
        end
        S_READ: begin
          ent_q  <= rd_ent;
          mask_q <= mask_c;
          to_n_q <= !is_ntob;
          if (mask_c == '0) begin
            dir_we_o <= 1'b1;
            state    <= S_WRITE;
          end else begin
            probe_valid_o <= 1'b1;
            state         <= S_PSEND;
          end
        end
        S_PSEND: if (probe_ready_i) begin
          probe_valid_o <= 1'b0;
          state         <= S_PWAIT;
        end
        S_PWAIT: if (trk_done) begin
          dir_we_o <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          dir_we_o      <= 1'b0;
          grant_valid_o <= 1'b1;
          state         <= S_GRANT;
        end
        S_GRANT: if (grant_ready_i) begin
          grant_valid_o <= 1'b0;
          req_ready_o   <= 1'b1;
          busy_o        <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64g_l2_dir_ctrl.sv
// Randomized and directed bench for rv64g_l2_dir_ctrl against a per-core
// transaction-level coherence model.
module tb_rv64g_l2_dir_ctrl;

  localparam int SETS = 256, WAYS = 16, CORES = 4;
  localparam int SW = 8, WW = 4, CW = 2;

  typedef struct packed {
    logic       v;
    logic [3:0] s;
    logic       ov;
    logic [1:0] oid;
    logic       d;
  } ent_t;

  typedef struct packed {
    logic [3:0]    mask;
    logic          to_n;
    logic [3:0]    ws;
    logic          wov;
    logic [1:0]    woid;
    logic          wd;
    logic          wb;
    logic          gperm;
    logic [SW-1:0] set;
    logic [WW-1:0] way;
    logic [1:0]    src;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 0, req_ready;
  logic [SW-1:0] req_set = '0;
  logic [WW-1:0] req_way = '0;
  logic [CW-1:0] req_src = '0;
  logic [1:0] req_perm = '0;
  logic [SW-1:0] dir_rd_set;
  logic [WAYS-1:0] rd_v = '0, rd_ov = '0, rd_d = '0;
  logic [WAYS*CORES-1:0] rd_s = '0;
  logic [WAYS*CW-1:0] rd_oid = '0;
  logic dir_we, wr_valid, wr_ov, wr_d;
  logic [SW-1:0] wr_set;
  logic [WW-1:0] wr_way;
  logic [CORES-1:0] wr_s;
  logic [CW-1:0] wr_oid;
  logic probe_valid, probe_ready = 0, probe_to_n;
  logic [CORES-1:0] probe_mask;
  logic ack_valid = 0, ack_dirty = 0;
  logic [CW-1:0] ack_src = '0;
  logic wb_dirty, grant_valid, grant_ready = 0, grant_perm, busy;
  logic [CW-1:0] grant_src;

  int checks = 0, errors = 0;
  bit in_txn = 0, probe_done = 0, we_done = 0;
  int acks_left = 0;
  exp_t cur = '0;

  always #5 clk = ~clk;

  rv64g_l2_dir_ctrl #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_set_i(req_set),
    .req_way_i(req_way), .req_src_i(req_src), .req_perm_i(req_perm),
    .dir_rd_set_o(dir_rd_set), .dir_rd_valid_i(rd_v), .dir_rd_sharers_i(rd_s),
    .dir_rd_owner_valid_i(rd_ov), .dir_rd_owner_id_i(rd_oid), .dir_rd_dirty_i(rd_d),
    .dir_we_o(dir_we), .dir_wr_set_o(wr_set), .dir_wr_way_o(wr_way),
    .dir_wr_valid_o(wr_valid), .dir_wr_sharers_o(wr_s), .dir_wr_owner_valid_o(wr_ov),
    .dir_wr_owner_id_o(wr_oid), .dir_wr_dirty_o(wr_d),
    .probe_valid_o(probe_valid), .probe_ready_i(probe_ready), .probe_mask_o(probe_mask),
    .probe_to_n_o(probe_to_n), .ack_valid_i(ack_valid), .ack_src_i(ack_src),
    .ack_dirty_i(ack_dirty), .wb_dirty_o(wb_dirty), .grant_valid_o(grant_valid),
    .grant_ready_i(grant_ready), .grant_src_o(grant_src), .grant_perm_o(grant_perm),
    .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who holds the line, who must be probed, and what the entry becomes.
  function automatic exp_t model(input ent_t e, input logic [1:0] src, input logic [1:0] perm,
                                 input logic dirty_any);
    exp_t r = '0;
    bit want_t = (perm != 2'd0);
    r.to_n  = want_t;
    r.gperm = want_t;
    for (int c = 0; c < 4; c++) begin
      bit sh  = e.v && e.s[c];
      bit own = e.v && e.ov && (int'(e.oid) == c);
      if (c != int'(src)) r.mask[c] = want_t ? (sh || own) : own;
    end
    if (!want_t) begin
      for (int c = 0; c < 4; c++)
        r.ws[c] = (e.v && e.s[c]) || (c == int'(src)) || r.mask[c];
      r.wb = (e.v && e.d) || dirty_any;
    end else begin
      r.wov  = 1'b1;
      r.woid = src;
      r.wd   = (e.v && e.ov && e.oid == src) ? e.d : 1'b0;
      r.wb   = dirty_any || (e.v && e.ov && e.d && e.oid != src);
    end
    return r;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e = '0;
    case ($urandom_range(0, 2))
      0: begin e.s = 4'($urandom); e.oid = 2'($urandom); end
      1: begin e.v = 1; e.s = 4'($urandom); end
      default: begin e.v = 1; e.ov = 1; e.oid = 2'($urandom); e.d = 1'($urandom); end
    endcase
    return e;
  endfunction

  task automatic fill_way(input int w, input ent_t e);
    rd_v[w] = e.v;
    rd_s[w*CORES +: CORES] = e.s;
    rd_ov[w] = e.ov;
    rd_oid[w*CW +: CW] = e.oid;
    rd_d[w] = e.d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_ack(input logic [1:0] core, input logic dirty);
    ack_valid = 1; ack_src = core; ack_dirty = dirty;
    step();
    ack_valid = 0; ack_dirty = 0;
  endtask

  // dmode: 0 random ack dirt, 1 all dirty, 2 all clean
  task automatic run_txn(input logic [SW-1:0] set, input logic [WW-1:0] way, input logic [1:0] src,
                         input logic [1:0] perm, input ent_t e, input int rdly, input bit early,
                         input bit spur, input logic [1:0] spur_core, input int dmode,
                         input bit ordered, input bit do_reset);
    logic [3:0] ackd;
    exp_t x;
    int q[$];
    int c, n;
    for (int w = 0; w < WAYS; w++) fill_way(w, rand_ent());
    fill_way(int'(way), e);
    x = model(e, src, perm, 1'b0);
    for (int k = 0; k < 4; k++) ackd[k] = (dmode == 0) ? 1'($urandom) : (dmode == 1);
    x = model(e, src, perm, |(ackd & x.mask));
    x.set = set; x.way = way; x.src = src;
    cur = x;
    acks_left = 0;
    for (int k = 3; k >= 0; k--) if (x.mask[k]) begin q.push_back(k); acks_left++; end
    if (!ordered)
      for (int i = 0; i < q.size(); i++) begin
        int j = $urandom_range(0, q.size() - 1);
        int t = q[i]; q[i] = q[j]; q[j] = t;
      end
    probe_done = 0;
    req_set = set; req_way = way; req_src = src; req_perm = perm; req_valid = 1;
    step();
    req_valid = 0;
    in_txn = 1;
    if (x.mask == 4'd0) begin
      chk("lat_c1_we", 32'(dir_we), 0);
      step();
      chk("lat_c2_we", 32'(dir_we), 1);
      step();
      chk("lat_c3_grant", 32'(grant_valid), 1);
    end else begin
      n = 0;
      while (!probe_valid && n < 10) begin step(); n++; end
      chk("probe_wait_timeout", 32'(probe_valid), 1);
      if (early && q.size() > 0) begin
        c = q.pop_front(); acks_left--;
        ack_valid = 1; ack_src = 2'(c); ack_dirty = ackd[c];
      end
      repeat (rdly) begin step(); ack_valid = 0; end
      probe_ready = 1;
      step();
      probe_ready = 0; ack_valid = 0; probe_done = 1;
      if (do_reset) begin
        rst_n = 0; in_txn = 0; acks_left = 0; probe_done = 0;
        step(); step();
        rst_n = 1;
        repeat (4) step();
        chk("post_reset_ready", 32'(req_ready), 1);
        return;
      end
      if (spur && q.size() > 0) send_ack(spur_core, 1'b1);
      while (q.size() > 0) begin
        repeat ($urandom_range(0, 2)) step();
        c = q.pop_front(); acks_left--;
        send_ack(2'(c), ackd[c]);
      end
    end
    n = 0;
    while (!grant_valid && n < 30) begin step(); n++; end
    chk("grant_timeout", 32'(grant_valid), 1);
    repeat ($urandom_range(0, 2)) step();
    chk("write_seen", 32'(we_done), 1);
    grant_ready = 1;
    step();
    grant_ready = 0; in_txn = 0;
  endtask

  // Per-cycle comparison of every output against the current expectation.
  initial forever begin
    @(negedge clk);
    chk("busy", 32'(busy), 32'(in_txn));
    chk("req_ready", 32'(req_ready), 32'(!in_txn));
    if (in_txn) chk("rd_set", 32'(dir_rd_set), 32'(cur.set));
    if (dir_we) begin
      chk("we_expected", 32'(in_txn && acks_left == 0 && !we_done &&
                             (cur.mask == 4'd0 || probe_done)), 1);
      chk("wr_addr", {16'd0, 4'd0, wr_set, wr_way}, {16'd0, 4'd0, cur.set, cur.way});
      chk("wr_valid", 32'(wr_valid), 1);
      chk("wr_sharers", 32'(wr_s), 32'(cur.ws));
      chk("wr_owner", {28'd0, wr_ov, wr_oid, wr_d}, {28'd0, cur.wov, cur.woid, cur.wd});
      we_done = 1;
    end
    chk("wb_dirty", 32'(wb_dirty), 32'(dir_we && in_txn && cur.wb));
    if (probe_valid) begin
      chk("probe_expected", 32'(in_txn && cur.mask != 4'd0 && !probe_done), 1);
      chk("probe_mask", 32'(probe_mask), 32'(cur.mask));
      chk("probe_to_n", 32'(probe_to_n), 32'(cur.to_n));
    end
    if (grant_valid) begin
      chk("grant_expected", 32'(in_txn && we_done), 1);
      chk("grant_src", 32'(grant_src), 32'(cur.src));
      chk("grant_perm", 32'(grant_perm), 32'(cur.gperm));
    end
    if (!in_txn) we_done = 0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    ent_t e;
    step(); step();
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", {29'd0, dir_we, probe_valid, grant_valid}, 0);
    rst_n = 1;
    step();

    e = '{v: 0, s: 4'b0000, ov: 0, oid: 0, d: 0};
    x = model(e, 2'd1, 2'd0, 1'b0);
    chk("pin1_mask", 32'(x.mask), 0);
    chk("pin1_ws", 32'(x.ws), 32'(4'b0010));
    run_txn(8'd10, 4'd5, 2'd1, 2'd0, e, 0, 0, 0, 2'd0, 0, 1, 0);

    e = '{v: 1, s: 4'b1010, ov: 0, oid: 0, d: 0};
    x = model(e, 2'd0, 2'd1, 1'b0);
    chk("pin2_mask", 32'(x.mask), 32'(4'b1010));
    chk("pin2_wr", {x.to_n, x.ws, x.wov, x.woid, x.wd}, {1'b1, 4'b0000, 1'b1, 2'd0, 1'b0});
    run_txn(8'd33, 4'd2, 2'd0, 2'd1, e, 1, 0, 0, 2'd0, 0, 1, 0);

    e = '{v: 1, s: 4'b0000, ov: 1, oid: 2, d: 1};
    x = model(e, 2'd3, 2'd0, 1'b1);
    chk("pin3_mask", 32'(x.mask), 32'(4'b0100));
    chk("pin3_wr", {x.to_n, x.ws, x.wov, x.wd, x.wb}, {1'b0, 4'b1100, 1'b0, 1'b0, 1'b1});
    run_txn(8'd77, 4'd9, 2'd3, 2'd0, e, 0, 0, 0, 2'd0, 1, 1, 0);

    e = '{v: 1, s: 4'b0000, ov: 1, oid: 3, d: 1};
    x = model(e, 2'd3, 2'd2, 1'b0);
    chk("pin4", {x.mask, x.wov, x.woid, x.wd, x.wb}, {4'b0000, 1'b1, 2'd3, 1'b1, 1'b0});
    run_txn(8'd200, 4'd15, 2'd3, 2'd2, e, 0, 0, 0, 2'd0, 0, 1, 0);

    e = '{v: 1, s: 4'b0000, ov: 1, oid: 2, d: 0};
    x = model(e, 2'd3, 2'd0, 1'b0);
    chk("pin5_wb", 32'(x.wb), 0);
    run_txn(8'd5, 4'd1, 2'd3, 2'd0, e, 3, 0, 1, 2'd0, 2, 1, 0);

    e = '{v: 1, s: 4'b1010, ov: 0, oid: 0, d: 0};
    run_txn(8'd6, 4'd3, 2'd0, 2'd1, e, 1, 0, 0, 2'd0, 0, 1, 1);

    e = '{v: 1, s: 4'b0000, ov: 1, oid: 1, d: 1};
    run_txn(8'd7, 4'd4, 2'd0, 2'd3, e, 0, 1, 0, 2'd0, 0, 1, 0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] src = 2'($urandom);
      run_txn(8'($urandom), 4'($urandom), src, 2'($urandom), rand_ent(),
              $urandom_range(0, 3), 1'($urandom), 1'($urandom), src, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv64g_l2_dir_ctrl.md
Name: rv64g_l2_dir_ctrl

Overview:
Coherence controller directly upstream of the L2 directory array. It accepts one Acquire per transaction after tag hit/allocation and reads the directory entry for that set/way. It issues probes to other cores when needed, counts probe acks, writes the updated entry back through the directory write port, then returns a Grant. Only one transaction is in flight at a time, so the block is not pipelined.

Parameters:
SETS, 256, directory sets; index width SW = $clog2(SETS)
WAYS, 16, ways per set; way width WW = $clog2(WAYS)
CORES, 4, coherent cores; id width CW = $clog2(CORES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  Acquire request valid
req_ready_o  out  1  accept; high only in IDLE
req_set_i  in  SW  target set
req_way_i  in  WW  target way (hit or newly allocated)
req_src_i  in  CW  requesting core
req_perm_i  in  2  0=NtoB, 1=NtoT, 2=BtoT; 3 treated as NtoT
dir_rd_set_o  out  SW  directory read index (combinational read array)
dir_rd_valid_i  in  WAYS  per-way valid
dir_rd_sharers_i  in  WAYS*CORES  per-way sharer vectors
dir_rd_owner_valid_i  in  WAYS  per-way owner valid
dir_rd_owner_id_i  in  WAYS*CW  per-way owner id
dir_rd_dirty_i  in  WAYS  per-way dirty
dir_we_o  out  1  directory write strobe, one cycle
dir_wr_set_o / dir_wr_way_o  out  SW / WW  write address
dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o  out  1/CORES/1/CW/1  entry to write
probe_valid_o  out  1  probe broadcast valid
probe_ready_i  in  1  probe accepted
probe_mask_o  out  CORES  cores to probe
probe_to_n_o  out  1  1=toN (invalidate), 0=toB (downgrade)
ack_valid_i  in  1  ProbeAck valid (always consumed)
ack_src_i  in  CW  acking core
ack_dirty_i  in  1  ack carried dirty data
wb_dirty_o  out  1  one-cycle pulse: L2 data line must be marked dirty
grant_valid_o  out  1  Grant valid
grant_ready_i  in  1  Grant accepted
grant_src_o  out  CW  destination core
grant_perm_o  out  1  0=Branch, 1=Trunk
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; pending mask=0; all *_valid_o, dir_we_o, wb_dirty_o, busy_o = 0; req_ready_o=1; captured registers=0. Reset mid-transaction abandons it without a write or a grant.
- States: IDLE -> READ -> (PROBE_SEND -> PROBE_WAIT)? -> WRITE -> GRANT -> IDLE.
- IDLE: on req_valid_i, capture set/way/src/perm and go to READ. dir_rd_set_o always drives the captured set.
- READ (1 cycle): register the selected way's entry (v, s, ov, oid, d) and compute the probe mask:
  - NtoB: mask = onehot(oid) if v&ov&(oid!=src), else 0; to_n=0.
  - NtoT/BtoT: mask = v ? ((s | (ov ? onehot(oid) : 0)) & ~onehot(src)) : 0; to_n=1.
  - mask==0 -> WRITE; else load pending=mask -> PROBE_SEND.
- PROBE_SEND: probe_valid_o=1 with mask/to_n held stable until probe_ready_i, then PROBE_WAIT.
- Acks are accepted in both PROBE_SEND and PROBE_WAIT. Each ack clears pending[ack_src_i]. An ack for a non-pending core is ignored. Any accepted ack with ack_dirty_i=1 sets a sticky dirty_seen flag.
- PROBE_WAIT: when pending==0 (including a same-cycle final clear), go to WRITE next cycle.
- WRITE (1 cycle): dir_we_o=1, address = captured set/way, valid=1.
  - NtoB: ov=0, oid=0, d=0, sharers = (v ? s : 0) | onehot(src) | (probed owner ? onehot(oid) : 0). If the old entry was dirty or dirty_seen, pulse wb_dirty_o.
  - NtoT/BtoT: sharers=0, ov=1, oid=src, d = (v&ov&oid==src) ? d : 0. Pulse wb_dirty_o if dirty_seen, or if the old entry was dirty with an owner other than src.
  - Written entries always satisfy: owner implies no sharers; dirty implies owner valid.
- GRANT: grant_valid_o=1, grant_src_o=src, grant_perm_o = (perm!=NtoB). Hold until grant_ready_i, then go to IDLE.
- Latency with no probe: accept at edge 0, READ cycle 1, WRITE cycle 2, grant_valid_o high in cycle 3.
- req_ready_o is low from the accept edge until GRANT completes. No back-to-back acceptance on the grant-handshake cycle.

Decomposition:
- rv64g_l2_pkg: perm encodings (PERM_NTOB/NTOT/BTOT), grant cap encodings, state enum, and the onehot helper function.
- One sub-module, rv64g_l2_probe_tracker: pending mask load/clear, ack filtering, dirty_seen flag, and the done output.

Test Plan:
- Invalid entry, set 10 way 5, src 1, NtoB -> no probe; dir write v=1 s=0010 ov=0; grant perm=0 in cycle 3.
- Entry s=1010, src 0, NtoT -> probe mask=1010 to_n=1; acks from 3 then 1 -> write s=0000 ov=1 oid=0 d=0; grant perm=1.
- Entry ov=1 oid=2 d=1, src 3, NtoB -> probe mask=0100 to_n=0; ack dirty=1 -> wb_dirty_o pulse; write s=1100 ov=0 d=0.
- Entry ov=1 oid=3 d=1, src 3, BtoT -> no probe; write ov=1 oid=3 d=1; wb_dirty_o stays 0.
- Spurious ack from core 0 while pending=0100 -> ignored and state stays PROBE_WAIT; probe_ready_i held low for 3 cycles -> probe_valid_o and probe_mask_o stable throughout.
- Drop rst_n during PROBE_WAIT -> no dir_we_o, no grant; req_ready_o=1 after reset release.
